// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings, FSM states and constants for the M-extension sequencer
//
// Purpose: funct3 op encodings, FSM state enumeration, iteration count and the
// special-case result constants, plus a small conditional-negate helper.
// Ports: none (package).

package mdu_pkg;

  localparam int unsigned MDU_ITER      = 32;
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Two's-complement negate when neg is set; used to take operand magnitudes.
  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one combinational shift-add or restoring-divide iteration
//
// Purpose: a single radix-2 iteration for both multiply and divide. Both
// results are always produced; the sequencer keeps whichever it needs.
// Ports:
//   i_prod    [63:0] product register: {partial high half, remaining multiplier bits}
//   i_rem     [31:0] current remainder (always < divisor)
//   i_quo     [31:0] dividend bits still to shift in / quotient bits shifted out
//   i_opb     [31:0] multiplicand magnitude (multiply) or divisor magnitude (divide)
//   o_prod    [63:0] product register after one add-shift
//   o_rem     [31:0] remainder after one trial subtract
//   o_quo     [31:0] quotient/dividend register after one shift

module mdu_step (
  input  logic [63:0] i_prod,
  input  logic [31:0] i_rem,
  input  logic [31:0] i_quo,
  input  logic [31:0] i_opb,
  output logic [63:0] o_prod,
  output logic [31:0] o_rem,
  output logic [31:0] o_quo
);

  logic [32:0] w_sum;
  logic [32:0] w_part;
  logic [32:0] w_diff;
  logic        w_ge;

  // Multiply: add multiplicand into the high half when the multiplier LSB is
  // set, then shift right; the carry becomes the new MSB.
  assign w_sum  = {1'b0, i_prod[63:32]} + (i_prod[0] ? {1'b0, i_opb} : 33'd0);
  assign o_prod = {w_sum, i_prod[31:1]};

  // Divide: 33-bit partial remainder so the trial subtract's sign bit tells
  // us whether the divisor fits.
  assign w_part = {i_rem, i_quo[31]};
  assign w_diff = w_part - {1'b0, i_opb};
  assign w_ge   = ~w_diff[32];
  assign o_rem  = w_ge ? w_diff[31:0] : w_part[31:0];
  assign o_quo  = {i_quo[30:0], w_ge};

endmodule

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - 32-cycle iterative RISC-V M-extension multiply/divide unit
//
// Purpose: accepts one op in IDLE, iterates 32 cycles in CALC (divide-by-zero
// and signed overflow skip straight to DONE), pulses done with the result.
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        request a new op (sampled only in IDLE)
//   funct3 [2:0] op select (MUL..REMU)
//   op_a  [31:0] rs1 (multiplicand/dividend)
//   op_b  [31:0] rs2 (multiplier/divisor)
//   flush        abort any op in flight; wins over start
//   busy         high from the cycle after acceptance through the DONE cycle
//   done         one-cycle pulse, result valid in the same cycle
//   result[31:0] registered result, held until the next done

module mdu_sequencer
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  state_e      r_state;
  state_e      w_state_next;
  logic [5:0]  r_cnt;
  logic [2:0]  r_funct3;
  logic        r_neg;
  logic [31:0] r_opb;
  logic [63:0] r_prod;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_result;

  // ---------------- operand decode at acceptance ----------------
  logic        w_is_div;
  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_neg;
  logic        w_div0;
  logic        w_ovf;
  logic        w_bypass;
  logic [31:0] w_bypass_res;
  logic        w_accept;
  logic        w_last;

  assign w_is_div   = funct3[2];
  // MUL is treated as unsigned: its low 32 bits do not depend on signedness.
  assign w_a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                      (funct3 == F3_DIV)  || (funct3 == F3_REM);
  assign w_b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign w_a_neg    = w_a_signed & op_a[31];
  assign w_b_neg    = w_b_signed & op_b[31];
  assign w_a_mag    = cond_neg32(op_a, w_a_neg);
  assign w_b_mag    = cond_neg32(op_b, w_b_neg);
  // Remainder takes the dividend's sign; everything else the product of signs.
  assign w_neg      = (funct3 == F3_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_div0     = w_is_div & (op_b == 32'd0);
  assign w_ovf      = w_is_div & ~funct3[0] & (op_a == INT_MIN) & (op_b == 32'hFFFF_FFFF);
  assign w_bypass   = w_div0 | w_ovf;
  // funct3[1] distinguishes REM/REMU from DIV/DIVU.
  assign w_bypass_res = w_div0 ? (funct3[1] ? op_a : DIV0_QUOTIENT)
                               : (funct3[1] ? 32'd0 : INT_MIN);

  assign w_accept = (r_state == ST_IDLE) & start & ~flush;
  assign w_last   = (r_state == ST_CALC) & (r_cnt == 6'(MDU_ITER - 1));

  // ---------------- iteration datapath ----------------
  logic [63:0] w_step_prod;
  logic [31:0] w_step_rem;
  logic [31:0] w_step_quo;

  mdu_step u_step (
    .i_prod (r_prod),
    .i_rem  (r_rem),
    .i_quo  (r_quo),
    .i_opb  (r_opb),
    .o_prod (w_step_prod),
    .o_rem  (w_step_rem),
    .o_quo  (w_step_quo)
  );

  // Final sign fix uses the last iteration's combinational output so the
  // result lands on the CALC->DONE edge. The product is negated at full
  // 64-bit width before the high half is taken.
  logic [63:0] w_prod_fix;
  logic [31:0] w_div_raw;
  logic [31:0] w_div_fix;
  logic [31:0] w_final;

  assign w_prod_fix = r_neg ? (~w_step_prod + 64'd1) : w_step_prod;
  assign w_div_raw  = r_funct3[1] ? w_step_rem : w_step_quo;
  assign w_div_fix  = r_neg ? (~w_div_raw + 32'd1) : w_div_raw;
  assign w_final    = r_funct3[2] ? w_div_fix :
                      ((r_funct3[1:0] == 2'b00) ? w_prod_fix[31:0] : w_prod_fix[63:32]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= 6'd0;
      r_funct3 <= 3'd0;
      r_neg    <= 1'b0;
      r_opb    <= 32'd0;
      r_prod   <= 64'd0;
      r_rem    <= 32'd0;
      r_quo    <= 32'd0;
      r_result <= 32'd0;
    end else if (w_accept) begin
      r_cnt    <= 6'd0;
      r_funct3 <= funct3;
      r_neg    <= w_neg;
      r_opb    <= w_is_div ? w_b_mag : w_a_mag;
      r_prod   <= {32'd0, w_b_mag};
      r_rem    <= 32'd0;
      r_quo    <= w_a_mag;
      if (w_bypass) begin
        r_result <= w_bypass_res;
      end
    end else if ((r_state == ST_CALC) && !flush) begin
      r_cnt  <= r_cnt + 6'd1;
      r_prod <= w_step_prod;
      r_rem  <= w_step_rem;
      r_quo  <= w_step_quo;
      if (w_last) begin
        r_result <= w_final;
      end
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (start) w_state_next = w_bypass ? ST_DONE : ST_CALC;
        ST_CALC: if (w_last) w_state_next = ST_DONE;
        ST_DONE: w_state_next = ST_IDLE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy   = (r_state != ST_IDLE);
    done   = (r_state == ST_DONE);
    result = r_result;
  end

endmodule
